// File: rtl/fsk_zc_demod.sv
// rtl/fsk_zc_demod.sv - zero-crossing FSK demodulator with hysteresis, window resync and erasure flag
module fsk_zc_demod #(
    parameter int DW          = 11,
    parameter int MID         = 1024,
    parameter int HYST        = 16,
    parameter int SYM_LEN     = 256,
    parameter int CNTW        = 8,
    parameter int THRESH      = 12,
    parameter int DEAD        = 2,
    parameter int ONE_IS_HIGH = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable,
    input  logic [DW-1:0]   din,
    input  logic            sym_sync,
    output logic            dout,
    output logic            dout_valid,
    output logic            erasure,
    output logic [CNTW-1:0] sym_count
);

    localparam int PW = $clog2(SYM_LEN);
    localparam logic [DW-1:0]          HI_LVL  = DW'(MID + HYST);
    localparam logic [DW-1:0]          LO_LVL  = DW'(MID - HYST);
    localparam logic [PW-1:0]          LAST_PH = PW'(SYM_LEN - 1);
    localparam logic [CNTW-1:0]        CNT_MAX = '1;
    localparam logic [CNTW-1:0]        THR     = CNTW'(THRESH);
    localparam logic signed [CNTW:0]   DEAD_S  = (CNTW+1)'(DEAD);

    logic                   side;
    logic                   crossing;
    logic [PW-1:0]          phase;
    logic [CNTW-1:0]        count;
    logic [CNTW-1:0]        count_sat;
    logic signed [CNTW:0]   diff;
    logic                   hi;
    logic                   near;

    // count_sat already includes the current sample, so the window's last crossing is decided on
    always_comb begin
        crossing = 1'b0;
        if (enable) begin
            crossing = side ? (din <= LO_LVL) : (din >= HI_LVL);
        end
        count_sat = (crossing && (count != CNT_MAX)) ? count + CNTW'(1) : count;
        diff      = $signed({1'b0, count_sat}) - $signed({1'b0, THR});
        hi        = count_sat > THR;
        near      = (diff <= DEAD_S) && (diff >= -DEAD_S);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            side       <= 1'b0;
            phase      <= '0;
            count      <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            erasure    <= 1'b0;
            sym_count  <= '0;
        end else begin
            dout_valid <= 1'b0;
            if (crossing) begin
                side <= ~side;
            end
            // resync discards the partial window; an accompanying sample opens the new one
            if (sym_sync) begin
                phase <= enable ? PW'(1) : '0;
                count <= CNTW'(crossing);
            end else if (enable) begin
                if (phase == LAST_PH) begin
                    phase      <= '0;
                    count      <= '0;
                    sym_count  <= count_sat;
                    dout       <= (ONE_IS_HIGH != 0) ? hi : ~hi;
                    erasure    <= near;
                    dout_valid <= 1'b1;
                end else begin
                    phase <= phase + PW'(1);
                    count <= count_sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_fsk_zc_demod.sv
// tb/tb_fsk_zc_demod.sv - scoreboard bench for fsk_zc_demod with three parameter variants
`timescale 1ns/1ps
module tb_fsk_zc_demod;

    localparam int DW      = 11;
    localparam int MID     = 1024;
    localparam int HYST    = 16;
    localparam int SYM_LEN = 256;
    localparam int THRESH  = 12;
    localparam int DEAD    = 2;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [DW-1:0] din;
    logic          sym_sync;

    logic       dout_a, dv_a, er_a;
    logic [7:0] cnt_a;
    logic       dout_b, dv_b, er_b;
    logic [7:0] cnt_b;
    logic       dout_c, dv_c, er_c;
    logic [3:0] cnt_c;

    fsk_zc_demod dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .din(din), .sym_sync(sym_sync),
        .dout(dout_a), .dout_valid(dv_a), .erasure(er_a), .sym_count(cnt_a)
    );
    fsk_zc_demod #(.ONE_IS_HIGH(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .din(din), .sym_sync(sym_sync),
        .dout(dout_b), .dout_valid(dv_b), .erasure(er_b), .sym_count(cnt_b)
    );
    fsk_zc_demod #(.CNTW(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .enable(enable), .din(din), .sym_sync(sym_sync),
        .dout(dout_c), .dout_valid(dv_c), .erasure(er_c), .sym_count(cnt_c)
    );

    typedef struct {
        int cyc;
        int cnt;
        int d;
        int e;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];
    exp_t last_a, last_b, last_c;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int side_m, nsamp, ncross;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // decision a window of n raw crossings must produce for a given counter width and polarity
    function automatic exp_t make_exp(input int n, input int cntw, input int oih);
        exp_t r;
        int maxc, fin, hi;
        maxc  = (1 << cntw) - 1;
        fin   = (n > maxc) ? maxc : n;
        hi    = (fin > THRESH) ? 1 : 0;
        r.cyc = cyc + 1;
        r.cnt = fin;
        r.d   = (oih != 0) ? hi : 1 - hi;
        r.e   = (fin >= THRESH - DEAD && fin <= THRESH + DEAD) ? 1 : 0;
        return r;
    endfunction

    task automatic model_reset();
        side_m = 0;
        nsamp  = 0;
        ncross = 0;
        last_a = '{0, 0, 0, 0};
        last_b = '{0, 0, 0, 0};
        last_c = '{0, 0, 0, 0};
    endtask

    task automatic model_step(input logic en, input logic [DW-1:0] d, input logic sy);
        int cr;
        cr = 0;
        if (en) begin
            if (side_m == 0 && d >= MID + HYST) begin
                cr = 1; side_m = 1;
            end else if (side_m == 1 && d <= MID - HYST) begin
                cr = 1; side_m = 0;
            end
        end
        if (sy) begin
            nsamp  = en ? 1 : 0;
            ncross = cr;
        end else if (en) begin
            nsamp++;
            ncross += cr;
            if (nsamp == SYM_LEN) begin
                qa.push_back(make_exp(ncross, 8, 1));
                qb.push_back(make_exp(ncross, 8, 0));
                qc.push_back(make_exp(ncross, 4, 1));
                nsamp  = 0;
                ncross = 0;
            end
        end
    endtask

    task automatic drive(input logic en, input logic [DW-1:0] d, input logic sy);
        @(posedge clk);
        #1;
        enable   = en;
        din      = d;
        sym_sync = sy;
        model_step(en, d, sy);
    endtask

    task automatic check_out(input int which, input int d, input int e, input int cnt);
        exp_t x;
        int have;
        have = 0;
        case (which)
            0: if (qa.size() > 0) begin x = qa.pop_front(); last_a = x; have = 1; end
            1: if (qb.size() > 0) begin x = qb.pop_front(); last_b = x; have = 1; end
            default: if (qc.size() > 0) begin x = qc.pop_front(); last_c = x; have = 1; end
        endcase
        chk($sformatf("dut%0d dout_valid expected", which), have, 1);
        if (have == 1) begin
            chk($sformatf("dut%0d decision cycle", which), cyc, x.cyc);
            chk($sformatf("dut%0d sym_count", which), cnt, x.cnt);
            chk($sformatf("dut%0d dout", which), d, x.d);
            chk($sformatf("dut%0d erasure", which), e, x.e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (dv_a) check_out(0, int'(dout_a), int'(er_a), int'(cnt_a));
            if (dv_b) check_out(1, int'(dout_b), int'(er_b), int'(cnt_b));
            if (dv_c) check_out(2, int'(dout_c), int'(er_c), int'(cnt_c));
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, " dout"}, int'(dout_a), 0);
        chk({tag, " dout_valid"}, int'(dv_a), 0);
        chk({tag, " erasure"}, int'(er_a), 0);
        chk({tag, " sym_count"}, int'(cnt_a), 0);
        chk({tag, " dout_b"}, int'(dout_b), 0);
        chk({tag, " sym_count_c"}, int'(cnt_c), 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        enable   = 1'b0;
        sym_sync = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero(tag);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wave(input int period, input int n, input int gap_at, input int gap_len,
                        input int sync_at);
        for (int k = 0; k < n; k++) begin
            if (k == gap_at) begin
                repeat (gap_len) drive(1'b0, DW'($urandom), 1'b0);
            end
            drive(1'b1, ((k % period) < period / 2) ? DW'(1150) : DW'(900), k == sync_at);
        end
    endtask

    // one window of SYM_LEN enabled samples holding exactly n crossings; rnd adds gaps and resyncs
    task automatic crossings(input int n, input bit rnd);
        for (int i = 0; i < SYM_LEN; i++) begin
            logic [DW-1:0] d;
            if (rnd) begin
                while ($urandom_range(0, 7) == 0)
                    drive(1'b0, DW'($urandom), $urandom_range(0, 99) == 0);
            end
            if (i < n)
                d = side_m ? DW'($urandom_range(0, MID - HYST))
                           : DW'($urandom_range(MID + HYST, (1 << DW) - 1));
            else
                d = DW'($urandom_range(MID - HYST + 1, MID + HYST - 1));
            drive(1'b1, d, rnd && ($urandom_range(0, 299) == 0));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        din      = '0;
        sym_sync = 1'b0;
        model_reset();
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        wave(16, SYM_LEN, -1, 0, -1);
        do_reset("rst2");
        wave(64, SYM_LEN, -1, 0, -1);
        do_reset("rst3");
        for (int i = 0; i < SYM_LEN; i++) drive(1'b1, (i % 2) ? DW'(1034) : DW'(1014), 1'b0);
        do_reset("rst4");
        crossings(13, 1'b0);
        do_reset("rst5");
        crossings(15, 1'b0);
        crossings(11, 1'b0);
        do_reset("rst6");
        wave(16, SYM_LEN, 100, 40, -1);
        do_reset("rst7");
        wave(16, 200, -1, 0, -1);
        wave(16, SYM_LEN, -1, 0, 0);
        wave(16, SYM_LEN - 1, -1, 0, -1);
        wave(16, SYM_LEN, -1, 0, 0);
        wave(16, 128, -1, 0, -1);
        do_reset("midwin");
        wave(16, SYM_LEN, -1, 0, -1);

        for (int w = 0; w < 12; w++) crossings($urandom_range(0, 40), 1'b1);

        repeat (6) drive(1'b0, DW'($urandom), 1'b0);
        @(negedge clk);
        #1;
        chk("hold dout_a", int'(dout_a), last_a.d);
        chk("hold erasure_a", int'(er_a), last_a.e);
        chk("hold sym_count_a", int'(cnt_a), last_a.cnt);
        chk("hold dout_b", int'(dout_b), last_b.d);
        chk("hold sym_count_c", int'(cnt_c), last_c.cnt);
        chk("pending decisions a", qa.size(), 0);
        chk("pending decisions b", qb.size(), 0);
        chk("pending decisions c", qc.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
